// File: rtl/rob_fflags_ram_pkg.sv
// -----------------------------------------------------------------------------
// rob_fflags_ram_pkg
// Shared helpers and defaults for the multi-port ROB fflags RAM.
//   clog2_depth  : ceil(log2(n)) for address and count widths.
//   even_parity  : even-parity bit over the low 'width' bits of a 64-bit word,
//                  so one function serves any entry width up to 64.
// Optional feature macro used by the RAM files: ROB_FFLAGS_RAM_PARITY_EN.
// -----------------------------------------------------------------------------
package rob_fflags_ram_pkg;

    localparam int DEFAULT_DEPTH = 7;
    localparam int DEFAULT_WIDTH = 7;

    function automatic int clog2_depth(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic even_parity(input logic [63:0] data, input int width);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rob_fflags_ram_rdport.sv
// -----------------------------------------------------------------------------
// rob_fflags_ram_rdport
// One registered read port of the ROB fflags RAM: range check, write-first
// bypass from the current cycle's winning writes, and the output register.
// Optional feature macro: ROB_FFLAGS_RAM_PARITY_EN (adds i_par/i_hit_par/o_perr).
//
// Ports:
//   clock, reset      sole clock; synchronous active-high reset
//   clear             flush in progress this cycle (bypassed reads see valid=0)
//   i_en, i_addr      read enable and address
//   i_mem, i_vld      stored data array (flattened) and valid bits
//   i_hit, i_hit_data per-address "written this cycle" flag and winning data
//   i_par, i_hit_par  stored parity / parity being written (parity build only)
//   o_data, o_valid   registered read data and valid (hold when i_en=0)
//   o_perr            registered parity error (parity build only)
// -----------------------------------------------------------------------------
module rob_fflags_ram_rdport
    import rob_fflags_ram_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = clog2_depth(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   i_en,
    input  logic [AW-1:0]          i_addr,
    input  logic [DEPTH*WIDTH-1:0] i_mem,
    input  logic [DEPTH-1:0]       i_vld,
    input  logic [DEPTH-1:0]       i_hit,
    input  logic [DEPTH*WIDTH-1:0] i_hit_data,
`ifdef ROB_FFLAGS_RAM_PARITY_EN
    input  logic [DEPTH-1:0]       i_par,
    input  logic [DEPTH-1:0]       i_hit_par,
    output logic                   o_perr,
`endif
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid
);

    logic [WIDTH-1:0] w_rd_data;
    logic             w_rd_valid;
`ifdef ROB_FFLAGS_RAM_PARITY_EN
    logic             w_rd_perr;
`endif

    // Selecting by comparing against every legal index doubles as the range
    // check: an address >= DEPTH matches nothing and keeps the zero defaults.
    always_comb begin
        w_rd_data  = '0;
        w_rd_valid = 1'b0;
`ifdef ROB_FFLAGS_RAM_PARITY_EN
        w_rd_perr  = 1'b0;
`endif
        for (int a = 0; a < DEPTH; a++) begin
            if (i_addr == AW'(a)) begin
                if (i_hit[a]) begin
                    // Write-first: the new data is visible; a same-cycle clear
                    // still wins on the valid bit.
                    w_rd_data  = i_hit_data[a*WIDTH +: WIDTH];
                    w_rd_valid = !clear;
`ifdef ROB_FFLAGS_RAM_PARITY_EN
                    w_rd_perr  = !clear && (i_hit_par[a] !=
                                 even_parity(64'(i_hit_data[a*WIDTH +: WIDTH]), WIDTH));
`endif
                end else begin
                    w_rd_data  = i_mem[a*WIDTH +: WIDTH];
                    w_rd_valid = i_vld[a];
`ifdef ROB_FFLAGS_RAM_PARITY_EN
                    w_rd_perr  = i_vld[a] && (i_par[a] !=
                                 even_parity(64'(i_mem[a*WIDTH +: WIDTH]), WIDTH));
`endif
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
`ifdef ROB_FFLAGS_RAM_PARITY_EN
            o_perr  <= 1'b0;
`endif
        end else if (i_en) begin
            o_data  <= w_rd_data;
            o_valid <= w_rd_valid;
`ifdef ROB_FFLAGS_RAM_PARITY_EN
            o_perr  <= w_rd_perr;
`endif
        end
    end

endmodule

// File: rtl/rob_fflags_ram_mp.sv
// -----------------------------------------------------------------------------
// rob_fflags_ram_mp
// Multi-port per-ROB-entry exception-flag storage. Execution units write flags
// at writeback; commit reads them at retirement through registered read ports.
// There is no flow control: a write to a valid entry simply overwrites it.
// Optional feature macro: ROB_FFLAGS_RAM_PARITY_EN (per-entry even parity,
// w_perr_inject input, r_perr output).
//
// Ports:
//   clock     sole clock, all state on posedge
//   reset     synchronous active-high; clears valids and read outputs only
//   clear     invalidates all entries (beats same-cycle writes on valid)
//   w_en      [NUM_WRITE]        write enables
//   w_addr    [NUM_WRITE*AW]     write addresses, port k at [k*AW +: AW]
//   w_data    [NUM_WRITE*WIDTH]  write data, port k at [k*WIDTH +: WIDTH]
//   r_en      [NUM_READ]         read enables
//   r_addr    [NUM_READ*AW]      read addresses
//   r_data    [NUM_READ*WIDTH]   registered read data (latency 1)
//   r_valid   [NUM_READ]         registered valid bit of the entry read
//   num_valid                    popcount of the valid bits, 0..DEPTH
//   w_perr_inject [NUM_WRITE]    invert stored parity (parity build only)
//   r_perr    [NUM_READ]         registered parity error (parity build only)
// -----------------------------------------------------------------------------
module rob_fflags_ram_mp
    import rob_fflags_ram_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NUM_WRITE = 2,
    parameter int NUM_READ  = 2,
    // Derived from DEPTH; do not override.
    parameter int AW        = clog2_depth(DEPTH)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clear,
    input  logic [NUM_WRITE-1:0]              w_en,
    input  logic [NUM_WRITE*AW-1:0]           w_addr,
    input  logic [NUM_WRITE*WIDTH-1:0]        w_data,
    input  logic [NUM_READ-1:0]               r_en,
    input  logic [NUM_READ*AW-1:0]            r_addr,
    output logic [NUM_READ*WIDTH-1:0]         r_data,
    output logic [NUM_READ-1:0]               r_valid,
`ifdef ROB_FFLAGS_RAM_PARITY_EN
    input  logic [NUM_WRITE-1:0]              w_perr_inject,
    output logic [NUM_READ-1:0]               r_perr,
`endif
    output logic [clog2_depth(DEPTH+1)-1:0]   num_valid
);

    localparam int CW = clog2_depth(DEPTH + 1);

    logic [DEPTH*WIDTH-1:0] r_mem;
    logic [DEPTH-1:0]       r_vld;
    logic [DEPTH-1:0]       w_hit;
    logic [DEPTH*WIDTH-1:0] w_hit_data;
`ifdef ROB_FFLAGS_RAM_PARITY_EN
    logic [DEPTH-1:0]       r_par;
    logic [DEPTH-1:0]       w_hit_par;
`endif

    // Per-address write arbitration. Ports are scanned in ascending order so
    // the highest-index port writing an address overrides the lower ones.
    // Out-of-range addresses match no entry and are dropped.
    always_comb begin
        w_hit      = '0;
        w_hit_data = '0;
`ifdef ROB_FFLAGS_RAM_PARITY_EN
        w_hit_par  = '0;
`endif
        for (int a = 0; a < DEPTH; a++) begin
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (w_en[k] && (w_addr[k*AW +: AW] == AW'(a))) begin
                    w_hit[a]                     = 1'b1;
                    w_hit_data[a*WIDTH +: WIDTH] = w_data[k*WIDTH +: WIDTH];
`ifdef ROB_FFLAGS_RAM_PARITY_EN
                    w_hit_par[a] = even_parity(64'(w_data[k*WIDTH +: WIDTH]), WIDTH)
                                   ^ w_perr_inject[k];
`endif
                end
            end
        end
    end

    // Data (and parity) array: never reset, but a write in a reset cycle is
    // discarded because reset overrides everything that cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (w_hit[a]) begin
                    r_mem[a*WIDTH +: WIDTH] <= w_hit_data[a*WIDTH +: WIDTH];
`ifdef ROB_FFLAGS_RAM_PARITY_EN
                    r_par[a]                <= w_hit_par[a];
`endif
                end
            end
        end
    end

    // Clear beats same-cycle writes on the valid bits only.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_vld <= '0;
        end else begin
            r_vld <= r_vld | w_hit;
        end
    end

    // CW holds DEPTH, so the count never wraps.
    always_comb begin
        num_valid = '0;
        for (int a = 0; a < DEPTH; a++) begin
            num_valid = num_valid + CW'(r_vld[a]);
        end
    end

    for (genvar j = 0; j < NUM_READ; j++) begin : g_rd
        rob_fflags_ram_rdport #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH),
            .AW    (AW)
        ) u_rdport (
            .clock      (clock),
            .reset      (reset),
            .clear      (clear),
            .i_en       (r_en[j]),
            .i_addr     (r_addr[j*AW +: AW]),
            .i_mem      (r_mem),
            .i_vld      (r_vld),
            .i_hit      (w_hit),
            .i_hit_data (w_hit_data),
`ifdef ROB_FFLAGS_RAM_PARITY_EN
            .i_par      (r_par),
            .i_hit_par  (w_hit_par),
            .o_perr     (r_perr[j]),
`endif
            .o_data     (r_data[j*WIDTH +: WIDTH]),
            .o_valid    (r_valid[j])
        );
    end

endmodule
